mul_unit: RTL and testbench
===========================

# mul_unit

Iterative multicycle multiplier driven by the controller's data-processing decode. Executes MUL, UMULL and SMULL, selected by the 3-bit ALUControl encoding, over 34 cycles with a start/busy/done handshake. Sits beside the ALU in the datapath: the main FSM holds in its execute state until `done`, then writes back `result_lo`, plus `result_hi` for the long forms. Also drives the N/Z flags for condlogic.

## Interface
- `WIDTH`, 32: operand width; the product is 2×WIDTH.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  3  ALUControl encoding: 3'b100 MUL, 3'b101 UMULL, 3'b110 SMULL.
- `a`  in  WIDTH  multiplicand (Rn).
- `b`  in  WIDTH  multiplier (Rm).
- `busy`  out  1  high from the cycle after an accepted start until `done` falls.
- `done`  out  1  one-cycle pulse; results valid.
- `result_lo`  out  WIDTH  low product word.
- `result_hi`  out  WIDTH  high product word; 0 for MUL.
- `flags`  out  2  {N, Z}; C/V are not produced.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE → CALC.** Transition when `start` is high and `op` is one of {100, 101, 110}. Latch `op`. Latch operand magnitudes:
  - SMULL: |a| and |b|, with `neg_q = a[31]^b[31]`.
  - Otherwise: raw a and b, with `neg_q = 0`.
  - The magnitude of 0x80000000 is 0x80000000; it fits unsigned.
- **Unsupported op.** If `start` is high with any other `op`, ignore it and stay in IDLE.
- **CALC.** 32 iterations of radix-2 shift-add:
  - 64-bit accumulator; multiplier shifted right; multiplicand shifted left.
  - 5-bit counter loads 31 and decrements.
  - Leave CALC after the iteration at count 0.
- **FIX.** Apply the conditional two's-complement negate to the 64-bit product when `neg_q` is set. Register the results:
  - `result_lo` = P[31:0].
  - `result_hi` = P[63:32], forced to 0 for MUL.
  - N = P[63] for long forms, P[31] for MUL.
  - Z = (P == 0) for long forms, (P[31:0] == 0) for MUL.
- **DONE.** `done` = 1 for one cycle, then go to IDLE.
- **Held outputs.** `result_*` and `flags` hold until the next FIX.
- **`start` while busy.** Ignored; no queueing.
- **`start` in the DONE cycle.** Ignored; it is accepted only from IDLE, one cycle later.
- **Reset, including mid-CALC.** Next state IDLE. `busy`, `done`, `result_lo`, `result_hi` and `flags` all go to 0, and the counter goes to 0.

## Timing
- Start accepted at edge E0.
- CALC occupies the cycles after E0 … E31 (32 cycles).
- FIX follows E32.
- `done` is high in the cycle after E33, i.e. 34 cycles after the accepting edge.
- Back-to-back minimum spacing is 35 cycles.
- `busy` is registered: it rises the cycle after E0 and falls together with `done` at E34.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - `MUL_OP` = 3'b100, `UMULL_OP` = 3'b101, `SMULL_OP` = 3'b110 (the same encodings the decoder emits).
  - The state enum {IDLE, CALC, FIX, DONE}.
- One sub-module is natural: `cond_neg`, a parameterised-width two's-complement conditional negate.
  - Instantiated twice at WIDTH for the operand magnitudes.
  - Instantiated once at 2×WIDTH for the product.
- State, counter and result registers use the existing `flopr`/`flopenr` cells.

## Test plan
- **UMULL.** 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001, flags N=1 Z=0. `done` exactly 34 cycles after start; `busy` high 34 cycles.
- **SMULL.**
  - −1 × 2 → hi 0xFFFFFFFF, lo 0xFFFFFFFE, N=1.
  - 0x80000000 × 0x80000000 → hi 0x40000000, lo 0, N=0 Z=0.
- **MUL.**
  - 7 × 6 → lo 42, hi 0, N=0 Z=0.
  - 0x00010000 × 0x00010000 → lo 0, hi 0, Z=1 (low-word zero test).
- **Handshake.**
  - `start` pulsed with a different operand mid-CALC and again in the DONE cycle → both ignored; first result unchanged.
  - A new start in the following IDLE cycle completes normally.
- **Invalid op.** `start` with op=3'b000 → no `busy`, no `done`; prior results retained.
- **Reset.** `reset` asserted at CALC iteration 10 → next cycle IDLE, all outputs 0, no `done`. A subsequent UMULL 3 × 5 → lo 15, hi 0 at 34 cycles.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative multiplier: ALUControl encodings it
// accepts and the control FSM state type.
package mul_unit_pkg;

  localparam logic [2:0] MUL_OP   = 3'b100;
  localparam logic [2:0] UMULL_OP = 3'b101;
  localparam logic [2:0] SMULL_OP = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MUL_OP) || (op == UMULL_OP) || (op == SMULL_OP);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Start/busy/done handshake and operand/result bundle between the main
// controller (master) and the multiplier (slave).
interface mul_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [1:0]       flags;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, flags
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, flags
  );

endinterface

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/mul_unit_cond_neg.sv
// Conditional two's-complement negate; a passes through when neg is low.
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] din_s;

  always_comb begin
    din_s = din;
    dout  = neg ? -din_s : din_s;
  end

endmodule

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for MUL/UMULL/SMULL: 32 CALC cycles on operand
// magnitudes, then one FIX cycle that re-applies the sign and registers results.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mul_unit_if.slave    bus
);

  import mul_unit_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic [1:0]       state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [1:0]       flags_q, flags_d;

  logic             sgn_op;
  logic             long_op;
  logic             fix_en;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]    prod;

  // Operand magnitudes are taken straight off the bus so they can be latched
  // on the accepting edge; |0x80000000| stays 0x80000000 as an unsigned value.
  assign sgn_op = (bus.op == SMULL_OP);

  cond_neg #(.WIDTH(WIDTH)) u_neg_a (
    .neg  (sgn_op & bus.a[WIDTH-1]),
    .din  (bus.a),
    .dout (mag_a)
  );

  cond_neg #(.WIDTH(WIDTH)) u_neg_b (
    .neg  (sgn_op & bus.b[WIDTH-1]),
    .din  (bus.b),
    .dout (mag_b)
  );

  cond_neg #(.WIDTH(PW)) u_neg_p (
    .neg  (neg_q),
    .din  (acc_q),
    .dout (prod)
  );

  always_comb begin
    state_d  = state_t'(state_q);
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    op_d     = op_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.start && is_mul_op(bus.op)) begin
          state_d  = CALC;
          op_d     = bus.op;
          neg_d    = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          cnt_d    = CNT_W'(WIDTH - 1);
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flops follow the next state so busy/done come straight from registers.
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    long_op = (op_q != MUL_OP);
    fix_en  = (state_q == FIX);
    lo_d    = prod[WIDTH-1:0];
    hi_d    = long_op ? prod[PW-1:WIDTH] : '0;
    flags_d = long_op ? {prod[PW-1], (prod == '0)}
                      : {prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
  end

  flopr #(.WIDTH(2))     u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_q));
  flopr #(.WIDTH(CNT_W)) u_cnt   (.clk(clk), .reset(reset), .d(cnt_d),   .q(cnt_q));
  flopr #(.WIDTH(1))     u_busy  (.clk(clk), .reset(reset), .d(busy_d),  .q(busy_q));
  flopr #(.WIDTH(1))     u_done  (.clk(clk), .reset(reset), .d(done_d),  .q(done_q));

  flopenr #(.WIDTH(WIDTH)) u_lo    (.clk(clk), .reset(reset), .en(fix_en), .d(lo_d),    .q(lo_q));
  flopenr #(.WIDTH(WIDTH)) u_hi    (.clk(clk), .reset(reset), .en(fix_en), .d(hi_d),    .q(hi_q));
  flopenr #(.WIDTH(2))     u_flags (.clk(clk), .reset(reset), .en(fix_en), .d(flags_d), .q(flags_q));

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    op_q     <= op_d;
    neg_q    <= neg_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit: products, flags, latency and handshake.
module tb_mul_unit;

  import mul_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mul_unit_if #(.WIDTH(32)) bus ();

  mul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Returns at the falling edge just after the accepting edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat is 1 in the first cycle after the accepting edge; 0 if done never came.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== 64'h0) begin
      miscompares++; $display("FAIL reset_result got %h_%h want 0", bus.result_hi, bus.result_lo);
    end
    vectors++;
    if (bus.flags !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", bus.flags); end
  endtask

  task automatic test_umull;
    int lat, bcnt;
    launch(UMULL_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL umull_latency got %0d want 34", lat); end
    vectors++;
    if (bcnt !== 34) begin miscompares++; $display("FAIL umull_busy_cycles got %0d want 34", bcnt); end
    vectors++;
    if (bus.result_hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL umull_hi got %h want fffffffe", bus.result_hi); end
    vectors++;
    if (bus.result_lo !== 32'h0000_0001) begin miscompares++; $display("FAIL umull_lo got %h want 00000001", bus.result_lo); end
    vectors++;
    if (bus.flags !== 2'b10) begin miscompares++; $display("FAIL umull_flags got %b want 10", bus.flags); end
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++; $display("FAIL umull_after_done busy/done got %b%b want 00", bus.busy, bus.done);
    end
  endtask

  task automatic test_smull;
    int lat, bcnt;
    launch(SMULL_OP, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(lat, bcnt);
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++; $display("FAIL smull_neg got %h_%h want ffffffff_fffffffe", bus.result_hi, bus.result_lo);
    end
    vectors++;
    if (bus.flags !== 2'b10) begin miscompares++; $display("FAIL smull_neg_flags got %b want 10", bus.flags); end
    launch(SMULL_OP, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bcnt);
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== 64'h4000_0000_0000_0000) begin
      miscompares++; $display("FAIL smull_min got %h_%h want 40000000_00000000", bus.result_hi, bus.result_lo);
    end
    vectors++;
    if (bus.flags !== 2'b00) begin miscompares++; $display("FAIL smull_min_flags got %b want 00", bus.flags); end
  endtask

  task automatic test_mul;
    int lat, bcnt;
    launch(MUL_OP, 32'd7, 32'd6);
    wait_done(lat, bcnt);
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== {32'd0, 32'd42}) begin
      miscompares++; $display("FAIL mul_small got %h_%h want 00000000_0000002a", bus.result_hi, bus.result_lo);
    end
    vectors++;
    if (bus.flags !== 2'b00) begin miscompares++; $display("FAIL mul_small_flags got %b want 00", bus.flags); end
    launch(MUL_OP, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat, bcnt);
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== 64'h0) begin
      miscompares++; $display("FAIL mul_lowzero got %h_%h want 0", bus.result_hi, bus.result_lo);
    end
    vectors++;
    if (bus.flags !== 2'b01) begin miscompares++; $display("FAIL mul_lowzero_flags got %b want 01", bus.flags); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    launch(MUL_OP, 32'd7, 32'd6);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 10) begin
        bus.start = 1'b1;
        bus.op    = UMULL_OP;
        bus.a     = 32'd1000;
        bus.b     = 32'd1000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL busy_start_latency got %0d want 34", lat); end
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== {32'd0, 32'd42}) begin
      miscompares++; $display("FAIL busy_start_result got %h_%h want 00000000_0000002a", bus.result_hi, bus.result_lo);
    end
    // Pulse start in the DONE cycle; it must not be taken.
    bus.start = 1'b1;
    bus.op    = UMULL_OP;
    bus.a     = 32'd123;
    bus.b     = 32'd456;
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++; $display("FAIL done_cycle_start busy/done got %b%b want 00", bus.busy, bus.done);
    end
    vectors++;
    if (bus.result_lo !== 32'd42) begin miscompares++; $display("FAIL done_cycle_result got %h want 0000002a", bus.result_lo); end
    // Now in IDLE: a start here is accepted at the very next edge.
    bus.op = MUL_OP;
    bus.a  = 32'd9;
    bus.b  = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL b2b_latency got %0d want 34", lat); end
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== {32'd0, 32'd81}) begin
      miscompares++; $display("FAIL b2b_result got %h_%h want 00000000_00000051", bus.result_hi, bus.result_lo);
    end
  endtask

  task automatic test_invalid_op;
    int seen;
    logic [2:0] bad_ops [2];
    bad_ops[0] = 3'b000;
    bad_ops[1] = 3'b111;
    for (int k = 0; k < 2; k++) begin
      launch(bad_ops[k], 32'd5, 32'd5);
      seen = 0;
      repeat (40) begin
        if (bus.busy || bus.done) seen++;
        @(negedge clk);
      end
      vectors++;
      if (seen !== 0) begin miscompares++; $display("FAIL invalid_op_%b activity got %0d cycles want 0", bad_ops[k], seen); end
    end
    vectors++;
    if ({bus.result_hi, bus.result_lo, bus.flags} !== {32'd0, 32'd81, 2'b00}) begin
      miscompares++; $display("FAIL invalid_op_retained got %h_%h %b want 00000000_00000051 00",
                              bus.result_hi, bus.result_lo, bus.flags);
    end
  endtask

  task automatic test_reset_mid_calc;
    int lat, bcnt, seen;
    launch(UMULL_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++; $display("FAIL midreset_busy_done got %b%b want 00", bus.busy, bus.done);
    end
    vectors++;
    if ({bus.result_hi, bus.result_lo, bus.flags} !== 66'h0) begin
      miscompares++; $display("FAIL midreset_outputs got %h_%h %b want 0", bus.result_hi, bus.result_lo, bus.flags);
    end
    seen = 0;
    repeat (40) begin
      if (bus.busy || bus.done) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
    launch(UMULL_OP, 32'd3, 32'd5);
    wait_done(lat, bcnt);
    vectors++;
    if (lat !== 34) begin miscompares++; $display("FAIL postreset_latency got %0d want 34", lat); end
    vectors++;
    if ({bus.result_hi, bus.result_lo} !== {32'd0, 32'd15}) begin
      miscompares++; $display("FAIL postreset_result got %h_%h want 00000000_0000000f", bus.result_hi, bus.result_lo);
    end
  endtask

  initial begin
    test_reset;
    test_umull;
    test_smull;
    test_mul;
    test_back_to_back;
    test_invalid_op;
    test_reset_mid_calc;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
